// File: rtl/uart_stim_driver.sv
// UART transmit stimulus source. Queues bytes with an error flag and serialises them onto
// txd_o, optionally corrupting the parity bit or the first stop bit of a frame.
module uart_stim_driver #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [7:0]                  wr_data_i,
  input  logic                        wr_valid_i,
  input  logic                        err_inject_i,
  output logic                        wr_ready_o,
  output logic                        txd_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        sent_o
);

  localparam int unsigned Divisor = CLK_FREQ_HZ / BAUD;
  localparam int unsigned TimerW  = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW  = AddrW + 1;

  localparam logic [TimerW-1:0] TimerMax = TimerW'(Divisor - 1);
  localparam logic [7:0]        DataMask = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0]        LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0]        LastStop = 3'(STOP_BITS - 1);
  localparam logic [LevelW-1:0] Full     = LevelW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               err_q, err_d;
  logic               txd_q, txd_d;
  logic               sent_q, sent_d;
  logic               ready_q;
  logic [LevelW-1:0]  level_q, level_d;
  logic [AddrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [8:0]         mem_q [FIFO_DEPTH];

  logic       push, pop, tick;
  logic [8:0] head;
  logic [7:0] head_data;
  logic       head_err;

  // ready_q keeps the FIFO closed until the first edge after reset is released
  assign wr_ready_o = ready_q && (level_q < Full);
  assign push       = rst_ni && wr_valid_i && wr_ready_o;
  assign head       = mem_q[rd_ptr_q];
  assign head_data  = head[7:0] & DataMask;
  assign head_err   = head[8];
  assign tick       = (timer_q == TimerMax);
  assign level_d    = level_q + LevelW'(push) - LevelW'(pop);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    err_d     = err_q;
    sent_d    = 1'b0;
    pop       = 1'b0;
    if (state_q != StIdle) timer_d = tick ? '0 : timer_q + 1'b1;
    unique case (state_q)
      StIdle: pop = (level_q != '0);
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (tick) begin
          if (bit_cnt_q == LastStop) begin
            sent_d  = 1'b1;
            state_d = StIdle;
            pop     = (level_q != '0);
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A pop always starts a fresh frame, whether from idle or straight after a stop bit
    if (pop) begin
      state_d   = StStart;
      timer_d   = '0;
      bit_cnt_d = '0;
      shreg_d   = head_data;
      err_d     = head_err;
      par_d     = (PARITY == 1) ? ~^head_data : ^head_data;
    end
  end

  // Line level for the current state; registered below, so txd lags the FSM by one cycle
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      StIdle:   txd_d = 1'b1;
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shreg_q[0];
      StParity: txd_d = par_q ^ err_q;
      StStop:   txd_d = !(err_q && (PARITY == 0) && (bit_cnt_q == '0));
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      err_q     <= 1'b0;
      txd_q     <= 1'b1;
      sent_q    <= 1'b0;
      ready_q   <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      err_q     <= err_d;
      txd_q     <= txd_d;
      sent_q    <= sent_d;
      ready_q   <= 1'b1;
      level_q   <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {err_inject_i, wr_data_i};
  end

  assign txd_o   = txd_q;
  assign sent_o  = sent_q;
  assign level_o = level_q;
  assign busy_o  = (state_q != StIdle) || (level_q != '0);

endmodule
